// File: rtl/fetch_unit.sv
// Instruction-fetch front end: a credit-limited PC generator drives a variable-latency
// instruction memory, and in-order responses are queued first-word-fall-through with their PCs.
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter int              ILEN       = 32,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr_out,
    output logic [XLEN-1:0] instr_pc
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;

    localparam logic [XLEN-1:0]  PC_INC     = XLEN'(ILEN / 8);
    localparam logic [XLEN-1:0]  ALIGN_MASK = XLEN'(ILEN / 8 - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1'b1);
    localparam logic [SUM_W-1:0] DEPTH_SUM  = SUM_W'(FIFO_DEPTH);

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~ALIGN_MASK;
    endfunction

    logic [XLEN-1:0]  fetch_pc_r;
    logic [XLEN-1:0]  resp_pc_r;
    logic [CNT_W-1:0] outst_r;
    logic [CNT_W-1:0] discard_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [ILEN-1:0]  data_q_r [FIFO_DEPTH];
    logic [XLEN-1:0]  pc_q_r   [FIFO_DEPTH];

    logic             credit_ok_s;
    logic             req_fire_s;
    logic             resp_live_s;
    logic             push_s;
    logic             pop_s;
    logic [CNT_W-1:0] outst_n_s;
    logic [CNT_W-1:0] discard_n_s;
    logic [CNT_W-1:0] count_n_s;
    logic [PTR_W-1:0] wr_ptr_n_s;
    logic [PTR_W-1:0] rd_ptr_n_s;
    logic [XLEN-1:0]  fetch_pc_n_s;
    logic [XLEN-1:0]  resp_pc_n_s;

    // Request gating: a slot is free only if neither a queued entry nor an in-flight fetch claims it
    always_comb begin
        credit_ok_s = ({1'b0, count_r} + {1'b0, outst_r}) < DEPTH_SUM;
        req_fire_s  = imem_req_valid && imem_req_ready;
    end

    assign imem_req_valid = rst && credit_ok_s && !redirect_valid;
    assign imem_req_addr  = fetch_pc_r;
    assign instr_valid    = (count_r != CNT_ZERO);
    assign instr_out      = data_q_r[rd_ptr_r];
    assign instr_pc       = pc_q_r[rd_ptr_r];

    // Next-state for counters, pointers and PCs; a redirect overrides all queue and PC updates
    always_comb begin
        resp_live_s = imem_resp_valid && (outst_r != CNT_ZERO);
        push_s      = resp_live_s && (discard_r == CNT_ZERO) && !redirect_valid;
        pop_s       = instr_valid && instr_ready && !redirect_valid;

        outst_n_s = outst_r;
        if (req_fire_s && !resp_live_s) begin
            outst_n_s = outst_r + CNT_ONE;
        end else if (!req_fire_s && resp_live_s) begin
            outst_n_s = outst_r - CNT_ONE;
        end else begin
            outst_n_s = outst_r;
        end

        // Everything still in flight after this cycle's response belongs to the old stream
        discard_n_s = discard_r;
        if (redirect_valid) begin
            discard_n_s = outst_n_s;
        end else if (resp_live_s && (discard_r != CNT_ZERO)) begin
            discard_n_s = discard_r - CNT_ONE;
        end else begin
            discard_n_s = discard_r;
        end

        count_n_s  = count_r;
        wr_ptr_n_s = wr_ptr_r;
        rd_ptr_n_s = rd_ptr_r;
        if (redirect_valid) begin
            count_n_s  = CNT_ZERO;
            wr_ptr_n_s = PTR_ZERO;
            rd_ptr_n_s = PTR_ZERO;
        end else begin
            if (push_s && !pop_s) begin
                count_n_s = count_r + CNT_ONE;
            end else if (!push_s && pop_s) begin
                count_n_s = count_r - CNT_ONE;
            end else begin
                count_n_s = count_r;
            end
            wr_ptr_n_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            rd_ptr_n_s = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        end

        fetch_pc_n_s = fetch_pc_r;
        resp_pc_n_s  = resp_pc_r;
        if (redirect_valid) begin
            fetch_pc_n_s = align_pc(redirect_pc);
            resp_pc_n_s  = align_pc(redirect_pc);
        end else begin
            fetch_pc_n_s = req_fire_s ? (fetch_pc_r + PC_INC) : fetch_pc_r;
            resp_pc_n_s  = push_s ? (resp_pc_r + PC_INC) : resp_pc_r;
        end
    end

    // State registers and queue storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_r <= RESET_PC;
            resp_pc_r  <= RESET_PC;
            outst_r    <= CNT_ZERO;
            discard_r  <= CNT_ZERO;
            count_r    <= CNT_ZERO;
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q_r[i] <= {ILEN{1'b0}};
                pc_q_r[i]   <= {XLEN{1'b0}};
            end
        end else begin
            fetch_pc_r <= fetch_pc_n_s;
            resp_pc_r  <= resp_pc_n_s;
            outst_r    <= outst_n_s;
            discard_r  <= discard_n_s;
            count_r    <= count_n_s;
            wr_ptr_r   <= wr_ptr_n_s;
            rd_ptr_r   <= rd_ptr_n_s;
            if (push_s) begin
                data_q_r[wr_ptr_r] <= imem_resp_data;
                pc_q_r[wr_ptr_r]   <= resp_pc_r;
            end
        end
    end

    fetch_unit_chk #(
        .XLEN       (XLEN),
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .resp_valid (imem_resp_valid),
        .outst      (outst_r),
        .push       (push_s),
        .count      (count_r),
        .req_valid  (imem_req_valid),
        .req_ready  (imem_req_ready),
        .req_addr   (imem_req_addr)
    );

endmodule

// Protocol properties for the fetch unit's memory channel and queue.
module fetch_unit_chk #(
    parameter int XLEN       = 32,
    parameter int CNT_W      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    input logic             resp_valid,
    input logic [CNT_W-1:0] outst,
    input logic             push,
    input logic [CNT_W-1:0] count,
    input logic             req_valid,
    input logic             req_ready,
    input logic [XLEN-1:0]  req_addr
);

    resp_needs_request: assert property (@(posedge clk) disable iff (!rst)
        resp_valid |-> (outst != {CNT_W{1'b0}}));

    no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
        push |-> (count < CNT_W'(FIFO_DEPTH)));

    addr_stable_while_stalled: assert property (@(posedge clk) disable iff (!rst)
        (req_valid && !req_ready) |=> $stable(req_addr));

endmodule
